// File: rtl/wasm_operand_stack.sv
// ---------------------------------------------------------------------------
// wasm_operand_stack
//   Value/operand stack for the WASM execution core. It sits directly in front
//   of the ALU and exposes the top three entries as operands A/B/C. It commits
//   the ALU result (or push data / a duplicate of the top) back to the stack
//   with the pop/push count of the issued op. A single op commits per cycle.
//   On overflow or underflow the stack enters a sticky trap state, which only
//   reset can clear.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   i_op_valid     operation request
//   o_op_ready     high while running (not trapped)
//   i_op_code      0 NOP, 1 PUSH, 2 DROP, 3 UNARY, 4 BINARY, 5 TERNARY, 6 DUP
//   i_push_data    value written by PUSH
//   i_alu_result   ALU result written by UNARY/BINARY/TERNARY
//   o_tos_a        entry at depth-1 (0 if empty)
//   o_nos_b        entry at depth-2 (0 if depth<2)
//   o_third_c      entry at depth-3 (0 if depth<3)
//   o_depth        number of entries, 0..DEPTH
//   o_empty        depth==0
//   o_full         depth==DEPTH
//   o_trap         sticky error flag
//   o_trap_cause   0 none, 1 underflow, 2 overflow
// ---------------------------------------------------------------------------
module wasm_operand_stack #(
  parameter int ST_WIDTH = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_op_valid,
  output logic                o_op_ready,
  input  logic [2:0]          i_op_code,
  input  logic [ST_WIDTH-1:0] i_push_data,
  input  logic [31:0]         i_alu_result,
  output logic [ST_WIDTH-1:0] o_tos_a,
  output logic [ST_WIDTH-1:0] o_nos_b,
  output logic [ST_WIDTH-1:0] o_third_c,
  output logic [ADDR_W:0]     o_depth,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_trap,
  output logic [1:0]          o_trap_cause
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_UNARY   = 3'd3;
  localparam logic [2:0] OP_BINARY  = 3'd4;
  localparam logic [2:0] OP_TERNARY = 3'd5;
  localparam logic [2:0] OP_DUP     = 3'd6;

  localparam logic [ADDR_W:0] DEPTH_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W:0]     r_depth;
  logic [1:0]          r_trapCause;
  logic [ST_WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]          w_need;
  logic [1:0]          w_pop;
  logic                w_push;
  logic                w_accept;
  logic                w_underflow;
  logic                w_overflow;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_idxA;
  logic [ADDR_W-1:0]   w_idxB;
  logic [ADDR_W-1:0]   w_idxC;
  logic [ADDR_W-1:0]   w_wrIdx;
  logic [ST_WIDTH-1:0] w_wrData;
  logic [ST_WIDTH-1:0] w_aluExt;

  // Per-op stack effect: entries required, removed and added.
  // Code 7 falls into the default and behaves as a NOP.
  always_comb begin
    w_need = 2'd0;
    w_pop  = 2'd0;
    w_push = 1'b0;
    case (i_op_code)
      OP_PUSH:    begin w_need = 2'd0; w_pop = 2'd0; w_push = 1'b1; end
      OP_DROP:    begin w_need = 2'd1; w_pop = 2'd1; w_push = 1'b0; end
      OP_UNARY:   begin w_need = 2'd1; w_pop = 2'd1; w_push = 1'b1; end
      OP_BINARY:  begin w_need = 2'd2; w_pop = 2'd2; w_push = 1'b1; end
      OP_TERNARY: begin w_need = 2'd3; w_pop = 2'd3; w_push = 1'b1; end
      OP_DUP:     begin w_need = 2'd1; w_pop = 2'd0; w_push = 1'b1; end
      default:    begin w_need = 2'd0; w_pop = 2'd0; w_push = 1'b0; end
    endcase
  end

  // Only pure pushes (pop==0) can grow the stack, so only they can overflow.
  assign w_accept    = i_op_valid & o_op_ready;
  assign w_underflow = w_accept & (r_depth < (ADDR_W+1)'(w_need));
  assign w_overflow  = w_accept & w_push & (w_pop == 2'd0) & (r_depth == DEPTH_MAX);
  assign w_commit    = w_accept & ~w_underflow & ~w_overflow;

  // Indices are computed modulo DEPTH. When depth==DEPTH the low bits are zero
  // and subtracting wraps to the correct top slot.
  assign w_idxA  = r_depth[ADDR_W-1:0] - ADDR_W'(1);
  assign w_idxB  = r_depth[ADDR_W-1:0] - ADDR_W'(2);
  assign w_idxC  = r_depth[ADDR_W-1:0] - ADDR_W'(3);
  assign w_wrIdx = r_depth[ADDR_W-1:0] - ADDR_W'(w_pop);

  assign o_tos_a   = (r_depth >= (ADDR_W+1)'(1)) ? r_mem[w_idxA] : '0;
  assign o_nos_b   = (r_depth >= (ADDR_W+1)'(2)) ? r_mem[w_idxB] : '0;
  assign o_third_c = (r_depth >= (ADDR_W+1)'(3)) ? r_mem[w_idxC] : '0;

  assign w_aluExt = ST_WIDTH'(i_alu_result);

  always_comb begin
    w_wrData = w_aluExt;
    if (i_op_code == OP_PUSH)
      w_wrData = i_push_data;
    else if (i_op_code == OP_DUP)
      w_wrData = o_tos_a;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_RUN;
    else
      r_state <= w_stateNext;
  end

  // Next state: any stack error traps, and TRAP is absorbing
  always_comb begin
    w_stateNext = r_state;
    if (r_state == ST_RUN && (w_underflow || w_overflow))
      w_stateNext = ST_TRAP;
  end

  // State-derived outputs
  always_comb begin
    o_op_ready = (r_state == ST_RUN);
    o_trap     = (r_state == ST_TRAP);
  end

  // Depth and trap cause. Both hold while trapped because nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth     <= '0;
      r_trapCause <= 2'd0;
    end else begin
      if (w_commit)
        r_depth <= r_depth - (ADDR_W+1)'(w_pop) + (ADDR_W+1)'(w_push);
      if (w_underflow)
        r_trapCause <= 2'd1;
      else if (w_overflow)
        r_trapCause <= 2'd2;
    end
  end

  // Storage has no reset; its contents are masked by depth
  always_ff @(posedge clk) begin
    if (w_commit && w_push)
      r_mem[w_wrIdx] <= w_wrData;
  end

  assign o_depth      = r_depth;
  assign o_empty      = (r_depth == '0);
  assign o_full       = (r_depth == DEPTH_MAX);
  assign o_trap_cause = r_trapCause;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_wasm_operand_stack
//   Self-checking bench for wasm_operand_stack. A queue-based stack model
//   tracks the expected contents, trap flag and cause. Directed vectors come
//   from a table. Hand-written sequences cover fill/overflow and reset during
//   an op. A randomized run is compared against the model.
// ---------------------------------------------------------------------------
module tb_wasm_operand_stack;

  localparam int ST_WIDTH = 32;
  localparam int DEPTH    = 64;
  localparam int ADDR_W   = 6;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_UNARY   = 3'd3;
  localparam logic [2:0] OP_BINARY  = 3'd4;
  localparam logic [2:0] OP_TERNARY = 3'd5;
  localparam logic [2:0] OP_DUP     = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                opValid = 1'b0;
  logic                opReady;
  logic [2:0]          opCode = 3'd0;
  logic [ST_WIDTH-1:0] pushData = '0;
  logic [31:0]         aluResult = '0;
  logic [ST_WIDTH-1:0] tosA, nosB, thirdC;
  logic [ADDR_W:0]     depth;
  logic                empty, full, trap;
  logic [1:0]          trapCause;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] model[$];
  bit          mTrap;
  logic [1:0]  mCause;

  wasm_operand_stack #(.ST_WIDTH(ST_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_op_valid   (opValid),
    .o_op_ready   (opReady),
    .i_op_code    (opCode),
    .i_push_data  (pushData),
    .i_alu_result (aluResult),
    .o_tos_a      (tosA),
    .o_nos_b      (nosB),
    .o_third_c    (thirdC),
    .o_depth      (depth),
    .o_empty      (empty),
    .o_full       (full),
    .o_trap       (trap),
    .o_trap_cause (trapCause)
  );

  always #5 clk = ~clk;

  // Single comparison. Prints one FAIL line on a mismatch.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    model.delete();
    mTrap  = 1'b0;
    mCause = 2'd0;
  endtask

  // Stack semantics taken straight from the op table
  task automatic modelStep(input logic [2:0] op, input logic [31:0] d, input logic [31:0] alu);
    int need, pop, push;
    logic [31:0] val;
    if (mTrap) return;
    case (op)
      OP_PUSH:    begin need = 0; pop = 0; push = 1; end
      OP_DROP:    begin need = 1; pop = 1; push = 0; end
      OP_UNARY:   begin need = 1; pop = 1; push = 1; end
      OP_BINARY:  begin need = 2; pop = 2; push = 1; end
      OP_TERNARY: begin need = 3; pop = 3; push = 1; end
      OP_DUP:     begin need = 1; pop = 0; push = 1; end
      default:    begin need = 0; pop = 0; push = 0; end
    endcase
    if (model.size() < need) begin
      mTrap = 1'b1; mCause = 2'd1; return;
    end
    if (push == 1 && pop == 0 && model.size() == DEPTH) begin
      mTrap = 1'b1; mCause = 2'd2; return;
    end
    if (op == OP_PUSH) val = d;
    else if (op == OP_DUP) val = model[model.size()-1];
    else val = alu;
    for (int i = 0; i < pop; i++) void'(model.pop_back());
    if (push == 1) model.push_back(val);
  endtask

  function automatic logic [31:0] modelAt(input int fromTop);
    if (model.size() > fromTop) return model[model.size()-1-fromTop];
    return 32'd0;
  endfunction

  // One accepted-or-not op: drive at negedge, commit at posedge, settle
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] d, input logic [31:0] alu);
    @(negedge clk);
    opValid   = 1'b1;
    opCode    = op;
    pushData  = d;
    aluResult = alu;
    @(posedge clk);
    modelStep(op, d, alu);
    #1;
    opValid = 1'b0;
  endtask

  // Compare every output against the model
  task automatic checkOutput(input string tag);
    check({tag, ".depth"}, 64'(depth), 64'(model.size()));
    check({tag, ".tos_a"}, 64'(tosA), 64'(modelAt(0)));
    check({tag, ".nos_b"}, 64'(nosB), 64'(modelAt(1)));
    check({tag, ".third_c"}, 64'(thirdC), 64'(modelAt(2)));
    check({tag, ".empty"}, 64'(empty), 64'(model.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(model.size() == DEPTH));
    check({tag, ".op_ready"}, 64'(opReady), 64'(!mTrap));
    check({tag, ".trap"}, 64'(trap), 64'(mTrap));
    check({tag, ".trap_cause"}, 64'(trapCause), 64'(mCause));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] alu;
    int          expDepth;
    logic [31:0] expTos;
    logic [31:0] expNos;
    logic [31:0] expThird;
    logic        expTrap;
    logic [1:0]  expCause;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] topBefore;
    string tag;

    // Directed sequence from reset; expectations worked out by hand
    vecs.push_back('{OP_PUSH,    32'd5, 32'd0,    1, 32'd5,    32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_PUSH,    32'd7, 32'd0,    2, 32'd7,    32'd5,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_BINARY,  32'd0, 32'd12,   1, 32'd12,   32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_DROP,    32'd0, 32'd0,    0, 32'd0,    32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_PUSH,    32'd1, 32'd0,    1, 32'd1,    32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_PUSH,    32'd2, 32'd0,    2, 32'd2,    32'd1,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_PUSH,    32'd3, 32'd0,    3, 32'd3,    32'd2,    32'd1, 1'b0, 2'd0});
    vecs.push_back('{OP_TERNARY, 32'd0, 32'hAA,   1, 32'hAA,   32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_UNARY,   32'd0, 32'h55,   1, 32'h55,   32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_DUP,     32'd0, 32'd0,    2, 32'h55,   32'h55,   32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_RSVD,    32'd9, 32'd9,    2, 32'h55,   32'h55,   32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_NOP,     32'd9, 32'd9,    2, 32'h55,   32'h55,   32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_DROP,    32'd0, 32'd0,    1, 32'h55,   32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_DROP,    32'd0, 32'd0,    0, 32'd0,    32'd0,    32'd0, 1'b0, 2'd0});
    vecs.push_back('{OP_DROP,    32'd0, 32'd0,    0, 32'd0,    32'd0,    32'd0, 1'b1, 2'd1});
    vecs.push_back('{OP_PUSH,    32'd9, 32'd0,    0, 32'd0,    32'd0,    32'd0, 1'b1, 2'd1});

    modelReset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    checkOutput("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].alu);
      tag = $sformatf("vec%0d", i);
      check({tag, ".depth"}, 64'(depth), 64'(vecs[i].expDepth));
      check({tag, ".tos_a"}, 64'(tosA), 64'(vecs[i].expTos));
      check({tag, ".nos_b"}, 64'(nosB), 64'(vecs[i].expNos));
      check({tag, ".third_c"}, 64'(thirdC), 64'(vecs[i].expThird));
      check({tag, ".trap"}, 64'(trap), 64'(vecs[i].expTrap));
      check({tag, ".trap_cause"}, 64'(trapCause), 64'(vecs[i].expCause));
      check({tag, ".op_ready"}, 64'(opReady), 64'(!vecs[i].expTrap));
      checkOutput({tag, ".model"});
    end

    // Reset while trapped clears the trap
    doReset();
    checkOutput("rst_trap");
    check("rst_trap.ready", 64'(opReady), 64'd1);

    // Fill to capacity, UNARY at full, then DUP overflows
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(OP_PUSH, $urandom, 32'd0);
    checkOutput("fill");
    check("fill.full", 64'(full), 64'd1);
    check("fill.depth", 64'(depth), 64'd64);
    applyStimulus(OP_UNARY, 32'd0, 32'h1234_5678);
    checkOutput("unary_full");
    check("unary_full.tos", 64'(tosA), 64'h1234_5678);
    topBefore = tosA;
    applyStimulus(OP_DUP, 32'd0, 32'd0);
    checkOutput("dup_ovf");
    check("dup_ovf.cause", 64'(trapCause), 64'd2);
    check("dup_ovf.depth", 64'(depth), 64'd64);
    check("dup_ovf.tos", 64'(tosA), 64'(topBefore));

    // Reset asserted during an op at depth 3: the op is discarded
    doReset();
    applyStimulus(OP_PUSH, 32'd1, 32'd0);
    applyStimulus(OP_PUSH, 32'd2, 32'd0);
    applyStimulus(OP_PUSH, 32'd3, 32'd0);
    checkOutput("pre_rst");
    @(negedge clk);
    opValid  = 1'b1;
    opCode   = OP_PUSH;
    pushData = 32'hDEAD;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_midop");
    @(negedge clk);
    opValid = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("rst_release");

    // Randomized ops against the model, with pushes weighted for depth growth
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] op;
      if (mTrap && ($urandom_range(0, 3) == 0)) begin
        doReset();
        checkOutput("rand_rst");
      end
      if ($urandom_range(0, 99) < 45) op = OP_PUSH;
      else op = 3'($urandom_range(0, 7));
      applyStimulus(op, $urandom, $urandom);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
